regfile_sequencer: RTL and testbench

Multi-cycle access controller that drives the read and write ports of the 4-entry general-purpose register file. Per accepted instruction it fetches two source operands, presents them to the ALU, waits for the ALU result, and optionally writes it back. Sits between the control unit (`start`/`done`) and the register file and ALU in the multi-cycle processor datapath.

---
 rtl/regfile_sequencer.sv | 125 ++++++++++++
 tb/tb_regfile_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Multi-cycle register-file access controller: fetch two operands, hand them to the ALU,
// wait for the result and optionally write it back. Optional ALU timeout: REGFILE_SEQ_TIMEOUT_EN.
module regfile_sequencer #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   instr_rs0,
    input  logic [1:0]   instr_rs1,
    input  logic [1:0]   instr_rd,
    input  logic         instr_wb,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   rd0_num,
    output logic [1:0]   rd1_num,
    input  logic [n-1:0] rd0_data,
    input  logic [n-1:0] rd1_data,
    output logic [n-1:0] a_out,
    output logic [n-1:0] b_out,
    output logic         alu_valid,
    input  logic         alu_ready,
    input  logic [n-1:0] alu_result,
    output logic [1:0]   wr_num,
    output logic [n-1:0] wr_data,
    output logic         wr_en
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] WB    = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [1:0] rd_q;
    logic       wb_q;
    logic       exec_timeout;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = EXEC;
            EXEC:    if (alu_ready || exec_timeout) state_next = WB;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd0_num <= '0;
            rd1_num <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
            a_out   <= '0;
            b_out   <= '0;
            wr_num  <= '0;
            wr_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd0_num <= instr_rs0;
                        rd1_num <= instr_rs1;
                        rd_q    <= instr_rd;
                        wb_q    <= instr_wb;
                    end
                end
                FETCH: begin
                    a_out <= rd0_data;
                    b_out <= rd1_data;
                end
                EXEC: begin
                    if (alu_ready) begin
                        wr_data <= alu_result;
                        wr_num  <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == WB);
    assign alu_valid = (state == EXEC);

`ifdef REGFILE_SEQ_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    logic       tmo_q;

    assign exec_timeout = (tmo_cnt == 4'd15) && !alu_ready;

    // tmo_q tracks the timeout decision each EXEC cycle and holds it through WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (state == FETCH) begin
                tmo_cnt <= '0;
            end else if (state == EXEC && !alu_ready) begin
                tmo_cnt <= tmo_cnt + 4'd1;
            end
            if (state == EXEC) begin
                tmo_q <= exec_timeout;
            end
        end
    end

    assign err   = done && tmo_q;
    assign wr_en = done && wb_q && !tmo_q;
`else
    assign exec_timeout = 1'b0;
    assign err          = 1'b0;
    // NOTE: wr_en decodes the state register, so an async reset drops a pending write immediately.
    assign wr_en        = done && wb_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: directed plus randomized operations against a
// register-file/ALU reference model kept at the operation level.
module tb_regfile_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] instr_rs0, instr_rs1, instr_rd;
    logic       instr_wb;
    logic       busy, done, err;
    logic [1:0] rd0_num, rd1_num;
    logic [7:0] rd0_data, rd1_data;
    logic [7:0] a_out, b_out;
    logic       alu_valid, alu_ready;
    logic [7:0] alu_result;
    logic [1:0] wr_num;
    logic [7:0] wr_data;
    logic       wr_en;

    // Register file attached to the DUT, plus a preload port used only by the bench.
    logic [7:0] rf [4];
    logic       pre_en;
    logic [1:0] pre_num;
    logic [7:0] pre_data;

    // Operation-level reference: register contents and the last result handed to wr_data.
    logic [7:0] ref_rf [4];
    logic [7:0] last_wr_data;

    int n_cmp, n_fail, done_cnt, ops_expected;

    regfile_sequencer #(.n(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .instr_rs0(instr_rs0), .instr_rs1(instr_rs1), .instr_rd(instr_rd), .instr_wb(instr_wb),
        .busy(busy), .done(done), .err(err),
        .rd0_num(rd0_num), .rd1_num(rd1_num), .rd0_data(rd0_data), .rd1_data(rd1_data),
        .a_out(a_out), .b_out(b_out), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_result(alu_result), .wr_num(wr_num), .wr_data(wr_data), .wr_en(wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd0_data = rf[rd0_num];
    assign rd1_data = rf[rd1_num];

    always @(posedge clk) begin
        if (wr_en === 1'b1) rf[wr_num] <= wr_data;
        else if (pre_en) rf[pre_num] <= pre_data;
    end

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag);
        for (int r = 0; r < 4; r++) check($sformatf("%s_r%0d", tag, r), rf[r], ref_rf[r]);
    endtask

    task automatic preload(input logic [1:0] num, input logic [7:0] val);
        pre_en = 1'b1; pre_num = num; pre_data = val;
        tick();
        pre_en = 1'b0;
        ref_rf[num] = val;
    endtask

    task automatic run_op(input logic [1:0] rs0, input logic [1:0] rs1, input logic [1:0] rd,
                          input logic wb, input logic [7:0] res, input int stall, input bit poke);
        logic [7:0] ea, eb;
        ea = ref_rf[rs0];
        eb = ref_rf[rs1];
        start = 1'b1; instr_rs0 = rs0; instr_rs1 = rs1; instr_rd = rd; instr_wb = wb;
        tick();
        // Instruction fields become garbage; an optional start pulse targets r0.
        start = poke; instr_rd = 2'd0; instr_wb = 1'b1;
        instr_rs0 = 2'($urandom); instr_rs1 = 2'($urandom);
        check("fetch_busy", busy, 1);
        check("fetch_rd0_num", rd0_num, rs0);
        check("fetch_rd1_num", rd1_num, rs1);
        check("fetch_alu_valid", alu_valid, 0);
        check("fetch_done", done, 0);
        tick();
        check("exec_a_out", a_out, ea);
        check("exec_b_out", b_out, eb);
        for (int i = 0; i < stall; i++) begin
            check("exec_alu_valid", alu_valid, 1);
            check("exec_done", done, 0);
            alu_ready = 1'b0; alu_result = 8'($urandom);
            tick();
            start = 1'b0;
        end
        check("exec_last_alu_valid", alu_valid, 1);
        check("exec_last_done", done, 0);
        alu_ready = 1'b1; alu_result = res;
        tick();
        start = 1'b0; alu_ready = 1'b0; alu_result = 8'($urandom);
        check("wb_done", done, 1);
        check("wb_wr_en", wr_en, wb);
        check("wb_wr_num", wr_num, rd);
        check("wb_wr_data", wr_data, res);
        check("wb_err", err, 0);
        check("wb_alu_valid", alu_valid, 0);
        check("wb_busy", busy, 1);
        if (wb) ref_rf[rd] = res;
        last_wr_data = res;
        ops_expected++;
        tick();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_wr_en", wr_en, 0);
        check("idle_wr_data_hold", wr_data, res);
        check_rf("after_op");
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; done_cnt = 0; ops_expected = 0;
        rst = 1'b1; start = 1'b0; instr_rs0 = '0; instr_rs1 = '0; instr_rd = '0; instr_wb = 1'b0;
        alu_ready = 1'b0; alu_result = '0; pre_en = 1'b0; pre_num = '0; pre_data = '0;
        last_wr_data = '0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_alu_valid", alu_valid, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_a_out", a_out, 0);
        check("rst_b_out", b_out, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_nums", {rd0_num, rd1_num, wr_num}, 0);
        @(posedge clk); #3 rst = 1'b0;
        tick();

        preload(2'd0, 8'h5A);
        preload(2'd1, 8'h12);
        preload(2'd2, 8'h34);
        preload(2'd3, 8'hC3);
        check_rf("preload");

        // Basic write-back, then a 5-cycle ALU stall, then a no-write-back operation.
        run_op(2'd1, 2'd2, 2'd3, 1'b1, 8'h46, 0, 1'b0);
        check("basic_r3", rf[3], 8'h46);
        run_op(2'd3, 2'd0, 2'd1, 1'b1, 8'hFF, 5, 1'b0);
        run_op(2'd2, 2'd3, 2'd2, 1'b0, 8'hAA, 1, 1'b0);
        // Start pulses during FETCH and EXEC must be ignored.
        run_op(2'd1, 2'd2, 2'd3, 1'b1, 8'h77, 2, 1'b1);
        // Idle without start stays idle.
        tick();
        check("idle_hold_busy", busy, 0);

        for (int k = 0; k < 20; k++) begin
            run_op(2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
                   int'($urandom_range(0, 6)), 1'($urandom));
        end

        // Reset in the middle of EXEC.
        start = 1'b1; instr_rs0 = 2'd1; instr_rs1 = 2'd2; instr_rd = 2'd3; instr_wb = 1'b1;
        tick();
        start = 1'b0;
        tick();
        alu_ready = 1'b0;
        tick();
        check("pre_rst_alu_valid", alu_valid, 1);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_alu_valid", alu_valid, 0);
        check("mid_rst_a_out", a_out, 0);
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_wr_data", wr_data, 0);
        @(posedge clk); #3 rst = 1'b0;
        tick();
        last_wr_data = '0;
        check_rf("after_rst_exec");

        // Reset during WB drops the pending write without a clock edge.
        start = 1'b1; instr_rs0 = 2'd0; instr_rs1 = 2'd1; instr_rd = 2'd0; instr_wb = 1'b1;
        tick();
        start = 1'b0;
        tick();
        alu_ready = 1'b1; alu_result = ~ref_rf[0];
        tick();
        alu_ready = 1'b0;
        check("pre_rst_wb_wr_en", wr_en, 1);
        #3 rst = 1'b1;
        #1;
        check("wb_rst_wr_en", wr_en, 0);
        check("wb_rst_done", done, 0);
        @(posedge clk); #3 rst = 1'b0;
        tick();
        check_rf("after_rst_wb");

        // Clean accept after reset.
        run_op(2'd2, 2'd1, 2'd0, 1'b1, 8'h3C, 0, 1'b0);

`ifdef REGFILE_SEQ_TIMEOUT_EN
        begin
            int cyc, valid_cycles;
            start = 1'b1; instr_rs0 = 2'd1; instr_rs1 = 2'd3; instr_rd = 2'd2; instr_wb = 1'b1;
            alu_ready = 1'b0;
            tick();
            start = 1'b0;
            cyc = 1; valid_cycles = 0;
            while (done !== 1'b1 && cyc < 40) begin
                if (alu_valid === 1'b1) valid_cycles++;
                tick();
                cyc++;
            end
            check("tmo_done_cycle", cyc, 18);
            check("tmo_exec_cycles", valid_cycles, 16);
            check("tmo_err", err, 1);
            check("tmo_wr_en", wr_en, 0);
            check("tmo_wr_data", wr_data, last_wr_data);
            ops_expected++;
            tick();
            check("tmo_idle_busy", busy, 0);
            check("tmo_idle_err", err, 0);
            check_rf("after_tmo");
        end
`endif

        tick();
        check("done_pulse_count", done_cnt, ops_expected);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
